// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter sharing the CPU data-memory bus.
// The CPU stores bytes into a small TX FIFO; they are sent as 8N1 frames, LSB first.
//
// Register window (16 bytes at BASE_ADDR, offset = addr[3:2], addr[1:0] ignored):
//   0 TXDATA   : write pushes wr_data[7:0]; reads 0
//   1 STATUS   : {count[7:4], overflow, empty, full, busy}; any write clears overflow
//   2 BAUD_DIV : clock cycles per bit, [15:0] read/write
//   3          : reads 0, writes ignored
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   wr_sig   - CPU store strobe
//   wr_data  - CPU store data
//   addr     - CPU data address
//   rd_data  - combinational read data, 0 when not selected
//   sel      - combinational window hit, used by the system read mux
//   tx       - serial line, registered, idles high
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_sig,
    input  logic [31:0] wr_data,
    input  logic [31:0] addr,
    output logic [31:0] rd_data,
    output logic        sel,
    output logic        tx
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [15:0]   r_baud;

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_div;
    logic [15:0]   w_div_next;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_next;
    logic          r_tx;
    logic          w_tx_next;
    logic          w_pop;

    logic          w_sel;
    logic [1:0]    w_off;
    logic          w_wr;
    logic          w_push_req;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic [7:0]    w_head;
    logic [15:0]   w_div_eff;
    logic [3:0]    w_cnt4;
    logic          w_unused;

    assign w_sel      = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = addr[3:2];
    assign w_wr       = wr_sig & w_sel;
    assign w_push_req = w_wr && (w_off == 2'd0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // Fullness is judged before the edge, so a pop in the same cycle cannot make room.
    assign w_push     = w_push_req & ~w_full;
    assign w_busy     = (r_state != S_IDLE);
    assign w_head     = r_mem[r_rptr];
    assign w_div_eff  = (r_baud == '0) ? 16'd1 : r_baud;
    assign w_cnt4     = 4'(r_count);
    assign w_unused   = &{1'b0, wr_data[31:16], addr[1:0]};

    assign sel = w_sel;
    assign tx  = r_tx;

    always_comb begin
        rd_data = '0;
        if (w_sel) begin
            case (w_off)
                2'd1:    rd_data[7:0]  = {w_cnt4, r_ovf, w_empty, w_full, w_busy};
                2'd2:    rd_data[15:0] = r_baud;
                default: rd_data = '0;
            endcase
        end
    end

    // FIFO storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_baud  <= DEFAULT_DIV;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == 2'd1)) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (w_off == 2'd2)) begin
                r_baud <= wr_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
        end
    end

    // Line level is computed for the state being entered, so tx is a pure flop output.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_div_next   = w_div_eff;
                    w_cnt_next   = w_div_eff - 16'd1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                    w_cnt_next   = r_div - 16'd1;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_cnt_next = r_div - 16'd1;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit + 3'd1;
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == '0) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_div_next   = w_div_eff;
                        w_cnt_next   = w_div_eff - 16'd1;
                        w_state_next = S_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        reset_n;
    logic        wr_sig;
    logic [31:0] wr_data;
    logic [31:0] addr;
    logic [31:0] rd_data;
    logic        sel;
    logic        tx;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_sig (wr_sig),
        .wr_data(wr_data),
        .addr   (addr),
        .rd_data(rd_data),
        .sel    (sel),
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr    = a;
        wr_data = d;
        wr_sig  = 1'b1;
        @(posedge clk);
        #1;
        wr_sig = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        wr_sig = 1'b0;
        addr   = a;
        #1;
        d = rd_data;
    endtask

    task automatic wait_start(input int bound, output bit found);
        found = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Entered in the first cycle of a start bit; samples every cycle of the frame.
    task automatic recv_frame(input int div, output logic [7:0] b, output bit ok);
        logic [9:0] bits;
        logic       v;
        ok   = 1'b1;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < div; c++) begin
                v = tx;
                if (c == 0) bits[k] = v;
                else if (v !== bits[k]) ok = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
        b = bits[8:1];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        bit          ok;
        bit          found;
        logic [7:0]  exp_b2b[3];

        exp_b2b[0] = 8'h01;
        exp_b2b[1] = 8'h80;
        exp_b2b[2] = 8'hFF;

        vecs[0]  = '{1'b0, BASE + 32'h0,  32'h0,         1'b1, 32'h0};
        vecs[1]  = '{1'b0, BASE + 32'h4,  32'h0,         1'b1, 32'h0000_0004};
        vecs[2]  = '{1'b0, BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0010};
        vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b0, BASE + 32'h9,  32'h0,         1'b1, 32'h0000_0010};
        vecs[5]  = '{1'b1, BASE + 32'h10, 32'h0000_1234, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0010};
        vecs[7]  = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, BASE + 32'h8,  32'hABCD_0003, 1'b1, 32'h0000_0010};
        vecs[9]  = '{1'b0, BASE + 32'hA,  32'h0,         1'b1, 32'h0000_0003};
        vecs[10] = '{1'b0, 32'h0000_2008, 32'h0,         1'b0, 32'h0};
        vecs[11] = '{1'b1, BASE + 32'h8,  32'h0,         1'b1, 32'h0000_0003};
        vecs[12] = '{1'b0, BASE + 32'h4,  32'h0,         1'b1, 32'h0000_0004};
        vecs[13] = '{1'b1, BASE + 32'h10, 32'h0000_0077, 1'b0, 32'h0};
        vecs[14] = '{1'b0, BASE + 32'h4,  32'h0,         1'b1, 32'h0000_0004};

        reset_n = 1'b0;
        wr_sig  = 1'b0;
        wr_data = '0;
        addr    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        bus_read(BASE + 32'h4, d);
        check("reset_status", d, 32'h0000_0004);
        bus_read(BASE + 32'h8, d);
        check("reset_baud", d, 32'h0000_0010);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Register decode vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            addr    = vecs[i].a;
            wr_data = vecs[i].d;
            wr_sig  = vecs[i].wr;
            #1;
            check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            wr_sig = 1'b0;
        end

        // BAUD_DIV is 0 here: behaves as 1 cycle per bit
        bus_write(BASE, 32'h0000_00C3);
        check("div0_tx_before", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        check("div0_tx_start", {31'd0, tx}, 32'd0);
        recv_frame(1, b, ok);
        check("div0_byte", {24'd0, b}, 32'h0000_00C3);
        check("div0_frame", {31'd0, ok}, 32'd1);
        wait_start(5, found);
        check("div0_no_extra", {31'd0, found}, 32'd0);

        // Single frame, 4 cycles per bit
        bus_write(BASE + 32'h8, 32'd4);
        bus_write(BASE, 32'h0000_0055);
        check("single_tx_edgeN", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        check("single_tx_edgeN1", {31'd0, tx}, 32'd0);
        bus_read(BASE + 32'h4, d);
        check("single_status_busy", d, 32'h0000_0005);
        recv_frame(4, b, ok);
        check("single_byte", {24'd0, b}, 32'h0000_0055);
        check("single_frame", {31'd0, ok}, 32'd1);
        bus_read(BASE + 32'h4, d);
        check("single_status_done", d, 32'h0000_0004);

        // Back-to-back frames, 2 cycles per bit
        bus_write(BASE + 32'h8, 32'd2);
        fork
            begin
                bus_write(BASE, 32'h0000_0001);
                bus_write(BASE, 32'h0000_0080);
                bus_write(BASE, 32'h0000_00FF);
            end
            begin
                logic [7:0] rb;
                bit         rok;
                bit         rf;
                wait_start(20, rf);
                check("b2b_start", {31'd0, rf}, 32'd1);
                for (int i = 0; i < 3; i++) begin
                    recv_frame(2, rb, rok);
                    check($sformatf("b2b_byte%0d", i), {24'd0, rb}, {24'd0, exp_b2b[i]});
                    check($sformatf("b2b_frame%0d", i), {31'd0, rok}, 32'd1);
                end
            end
        join
        wait_start(10, found);
        check("b2b_no_extra", {31'd0, found}, 32'd0);
        bus_read(BASE + 32'h4, d);
        check("b2b_status", d, 32'h0000_0004);

        // Overflow with a full FIFO, 16 cycles per bit
        bus_write(BASE + 32'h8, 32'd16);
        fork
            begin
                logic [31:0] sd;
                for (int i = 0; i < 6; i++) bus_write(BASE, 32'h10 + i);
                bus_read(BASE + 32'h4, sd);
                check("ovf_status_full", sd, 32'h0000_004B);
                bus_write(BASE + 32'h4, 32'h0);
                bus_read(BASE + 32'h4, sd);
                check("ovf_status_cleared", sd, 32'h0000_0043);
            end
            begin
                logic [7:0] rb;
                bit         rok;
                bit         rf;
                wait_start(20, rf);
                check("ovf_start", {31'd0, rf}, 32'd1);
                for (int i = 0; i < 5; i++) begin
                    recv_frame(16, rb, rok);
                    check($sformatf("ovf_byte%0d", i), {24'd0, rb}, 32'h10 + i);
                    check($sformatf("ovf_frame%0d", i), {31'd0, rok}, 32'd1);
                end
            end
        join
        wait_start(40, found);
        check("ovf_dropped", {31'd0, found}, 32'd0);
        bus_read(BASE + 32'h4, d);
        check("ovf_status_end", d, 32'h0000_0004);

        // Divisor change during a frame
        bus_write(BASE + 32'h8, 32'd4);
        fork
            begin
                logic [31:0] sd;
                bus_write(BASE, 32'h0000_000F);
                bus_write(BASE, 32'h0000_00F0);
                repeat (8) @(posedge clk);
                bus_write(BASE + 32'h8, 32'd8);
                bus_read(BASE + 32'h8, sd);
                check("divchg_baud", sd, 32'h0000_0008);
            end
            begin
                logic [7:0] rb;
                bit         rok;
                bit         rf;
                wait_start(20, rf);
                check("divchg_start", {31'd0, rf}, 32'd1);
                recv_frame(4, rb, rok);
                check("divchg_byte0", {24'd0, rb}, 32'h0000_000F);
                check("divchg_frame0", {31'd0, rok}, 32'd1);
                recv_frame(8, rb, rok);
                check("divchg_byte1", {24'd0, rb}, 32'h0000_00F0);
                check("divchg_frame1", {31'd0, rok}, 32'd1);
            end
        join
        bus_read(BASE + 32'h4, d);
        check("divchg_status", d, 32'h0000_0004);

        // Reset in the middle of a frame
        bus_write(BASE + 32'h8, 32'd4);
        bus_write(BASE, 32'h0000_00A5);
        repeat (14) @(posedge clk);
        #1;
        bus_read(BASE + 32'h4, d);
        check("midrst_busy_before", {31'd0, d[0]}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        bus_read(BASE + 32'h4, d);
        check("midrst_status_in_reset", d, 32'h0000_0004);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(BASE + 32'h4, d);
        check("midrst_status", d, 32'h0000_0004);
        bus_read(BASE + 32'h8, d);
        check("midrst_baud", d, 32'h0000_0010);
        wait_start(30, found);
        check("midrst_no_resume", {31'd0, found}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter.
- Responds to the CPU data-memory port (wr_sig / wr_data / addr / rd_data), alongside the RAM on the same bus.
- CPU stores bytes into a TX FIFO; the block serialises them as 8N1 frames, LSB first, on a single line.
- Gives programs a visible output channel beyond register-file inspection.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16, reset value of BAUD_DIV in clock cycles per bit.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_sig  input  1  store strobe from CPU, sampled on rising edge
- wr_data  input  32  store data from CPU
- addr  input  32  CPU data address
- rd_data  output  32  combinational read data; 0 when sel=0
- sel  output  1  combinational; 1 when addr[31:4] == BASE_ADDR[31:4]; system muxes rd_data against RAM
- tx  output  1  serial line, registered, idles high

Behaviour:
- Register map (offset = addr[3:2]; addr[1:0] ignored):
  - 0 TXDATA: write pushes wr_data[7:0]; reads 0.
  - 1 STATUS: read bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, rest 0. Any write clears overflow.
  - 2 BAUD_DIV: rw, 16 bits in [15:0], upper bits read 0.
  - 3: reads 0, writes ignored.
- Writes take effect only when wr_sig=1 and sel=1; all other writes are ignored.
- Reset (async assert, any time, including mid-frame):
  - tx=1, FIFO empty, count=0, overflow=0, BAUD_DIV=DEFAULT_DIV, FSM IDLE, counters 0.
  - rd_data/sel stay combinational.
  - No partial frame resumes after deassert.
- FIFO push/pop:
  - Push on TXDATA write if full was 0 before the edge.
  - If full, the byte is dropped and overflow is set.
  - A pop in the same cycle does not rescue the write.
  - Simultaneous push and pop with count unchanged is legal.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- Divisor handling:
  - Active divisor latched from BAUD_DIV on entering START; BAUD_DIV writes mid-frame affect only the next frame.
  - Latched value 0 is treated as 1.
  - Each bit lasts exactly div cycles, timed by a down-counter.
- IDLE: tx=1. If FIFO non-empty, pop head into shift register and go to START on the same edge.
- START: tx=0 for div cycles, then DATA with bit index 0.
- DATA: tx=shift[0] for div cycles, then shift right. After 8 bits, go to STOP.
- STOP: tx=1 for div cycles, then:
  - FIFO non-empty: pop and go directly to START (no idle gap).
  - Else: IDLE.
- Latency:
  - TXDATA write at edge N into empty FIFO while IDLE → tx falls at edge N+1.
  - Frame = 10*div cycles.
- tx never glitches: driven from a flop only.

Test Plan:
- Reset mid-frame: BAUD_DIV=4, write 8'hA5, assert reset_n=0 after 15 cycles → tx=1 immediately; after release STATUS reads 32'h0000_0004 and BAUD_DIV reads 16.
- Single frame: BAUD_DIV=4, write TXDATA=8'h55 → tx low at edge+1, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; busy=1 for 40 cycles, then STATUS = 32'h0000_0004.
- Back-to-back: DIV=2, write 8'h01, 8'h80, 8'hFF in consecutive cycles → three contiguous 20-cycle frames, no idle gap; decoded bytes 01, 80, FF.
- Overflow: DIV=16, write 6 bytes 8'h10..8'h15 in consecutive cycles (first popped) → bytes 10–14 sent, 15 dropped; STATUS bit3=1 and bit1=1 while full; any STATUS write clears bit3.
- Divisor change mid-frame: DIV=4, send 8'h0F, write BAUD_DIV=8 during DATA → current frame stays 40 cycles; next byte 8'hF0 frame is 80 cycles.
- Decode/sel: addr=BASE_ADDR+16 with wr_sig=1 → sel=0, rd_data=0, no state change; addr=BASE_ADDR+9 reads BAUD_DIV (addr[1:0] ignored); DIV=0 behaves as 1 (10-cycle frame).
